// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI reset sequencer: state encodings, default
// timing parameters and a small helper used to size the shared counter.
package hdmi_pkg;

  localparam int unsigned DefSyncStages       = 2;
  localparam int unsigned DefLockStableCycles = 1024;
  localparam int unsigned DefSerdesHoldCycles = 16;
  localparam int unsigned DefVideoDelayCycles = 16;

  typedef enum logic [2:0] {
    StWaitLock  = 3'd0,
    StStabilize = 3'd1,
    StSerdesRst = 3'd2,
    StVideoRst  = 3'd3,
    StRun       = 3'd4
  } state_e;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for bringing asynchronous signals into the clk domain.
// Each bit is synchronized independently; only use Width > 1 for unrelated bits.
module sync_ff #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[Depth-1];

endmodule

// File: rtl/hdmi_reset_sequencer.sv
// Brings up the HDMI serializers and video pipeline after PLL lock, in order:
// wait for stable lock, pulse serializer reset, then release the video domain.
module hdmi_reset_sequencer
  import hdmi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DefSyncStages,
  parameter int unsigned LOCK_STABLE_CYCLES = DefLockStableCycles,
  parameter int unsigned SERDES_HOLD_CYCLES = DefSerdesHoldCycles,
  parameter int unsigned VIDEO_DELAY_CYCLES = DefVideoDelayCycles
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       soft_reset_req,
  output logic       serdes_rst,
  output logic       video_rstn,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] relock_count
);

  localparam int unsigned MaxCycles =
      max3(LOCK_STABLE_CYCLES, SERDES_HOLD_CYCLES, VIDEO_DELAY_CYCLES);
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] SerdesLast = CntW'(SERDES_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] VideoLast  = CntW'(VIDEO_DELAY_CYCLES - 1);

  logic            lock_s;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      relock_q, relock_d;
  logic            serdes_rst_q, video_rstn_q, ready_q;

  sync_ff #(
    .Depth (SYNC_STAGES),
    .Width (1)
  ) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_lock),
    .q      (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    relock_d = relock_q;

    unique case (state_q)
      StWaitLock: begin
        cnt_d = '0;
        if (lock_s) state_d = StStabilize;
      end
      StStabilize: begin
        if (cnt_q == StableLast) begin
          state_d = StSerdesRst;
          cnt_d   = '0;
        end
      end
      StSerdesRst: begin
        if (cnt_q == SerdesLast) begin
          state_d = StVideoRst;
          cnt_d   = '0;
        end
      end
      StVideoRst: begin
        if (cnt_q == VideoLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = '0;
        if (soft_reset_req) state_d = StSerdesRst;
      end
      default: begin
        state_d = StWaitLock;
        cnt_d   = '0;
      end
    endcase

    // Lock loss overrides every other event, including a soft reset request.
    if (state_q != StWaitLock && !lock_s) begin
      state_d = StWaitLock;
      cnt_d   = '0;
      if (state_q == StRun && relock_q != 8'hff) relock_d = relock_q + 8'd1;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StWaitLock;
      cnt_q        <= '0;
      relock_q     <= '0;
      serdes_rst_q <= 1'b1;
      video_rstn_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      relock_q     <= relock_d;
      serdes_rst_q <= (state_d != StRun) && (state_d != StVideoRst);
      video_rstn_q <= (state_d == StRun);
      ready_q      <= (state_d == StRun);
    end
  end

  assign state        = state_q;
  assign relock_count = relock_q;
  assign serdes_rst   = serdes_rst_q;
  assign video_rstn   = video_rstn_q;
  assign ready        = ready_q;

endmodule

// File: doc/hdmi_reset_sequencer.md
HDMI_RESET_SEQUENCER -- requirements
Module: hdmi_reset_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the lock synchronizer depth (legal range 2..4).
REQ-002 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024, giving the consecutive locked cycles required before sequencing.
REQ-003 The block SHALL have parameter SERDES_HOLD_CYCLES, default 16, giving the serializer reset assertion length.
REQ-004 The block SHALL have parameter VIDEO_DELAY_CYCLES, default 16, giving the gap between serializer release and video release.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset: clk (input, 1, pixel clock, the divided HDMI clock) and resetn (input, 1, asynchronous active-low reset).
REQ-006 pll_lock  input  1  raw PLL lock, asynchronous to clk.
REQ-007 soft_reset_req  input  1  single-cycle request to re-run the serializer/video reset sequence.
REQ-008 serdes_rst  output  1  active-high reset for the TMDS serializers.
REQ-009 video_rstn  output  1  active-low reset for the timing generator and pixel pipeline.
REQ-010 ready  output  1  high only in RUN.
REQ-011 state  output  3  current state encoding.
REQ-012 relock_count  output  8  saturating count of lock losses observed in RUN.

Function
REQ-013 pll_lock SHALL pass through a SYNC_STAGES flip-flop synchronizer; every other reference to lock SHALL use the synchronized value lock_s.
REQ-014 States and encodings SHALL be: WAIT_LOCK=0, STABILIZE=1, SERDES_RST=2, VIDEO_RST=3, RUN=4.
REQ-015 WAIT_LOCK: when lock_s=1, the block SHALL go to STABILIZE and clear the shared counter.
REQ-016 STABILIZE: the counter SHALL increment each cycle. When it reaches LOCK_STABLE_CYCLES-1 with lock_s=1, the block SHALL go to SERDES_RST and clear the counter.
REQ-017 SERDES_RST: serdes_rst=1. After SERDES_HOLD_CYCLES cycles in this state, the block SHALL go to VIDEO_RST and clear the counter.
REQ-018 VIDEO_RST: serdes_rst=0 and video_rstn=0. After VIDEO_DELAY_CYCLES cycles, the block SHALL go to RUN.
REQ-019 RUN: serdes_rst=0, video_rstn=1, ready=1.
REQ-020 In any state except WAIT_LOCK, lock_s=0 SHALL force WAIT_LOCK on the next edge and clear the counter (lock loss has priority over all other events).
REQ-021 In every state except RUN, serdes_rst SHALL be 1 and video_rstn SHALL be 0, with the single exception of VIDEO_RST where serdes_rst=0.
REQ-022 soft_reset_req in RUN SHALL force SERDES_RST with the counter cleared; in any other state it SHALL be ignored.
REQ-023 soft_reset_req coincident with lock_s=0 SHALL go to WAIT_LOCK.
REQ-024 relock_count SHALL increment by 1 when leaving RUN because lock_s=0, and SHALL hold at 255.
REQ-025 All outputs SHALL be registered, changing on the same edge as the state change.
REQ-026 The counter width SHALL be clog2 of the largest of the three cycle parameters, plus 1.
REQ-027 Minimum latency from lock_s rising to ready rising SHALL be LOCK_STABLE_CYCLES + SERDES_HOLD_CYCLES + VIDEO_DELAY_CYCLES + 1 cycles.

Reset
REQ-028 While resetn=0, the block SHALL hold: state=WAIT_LOCK, synchronizer=0, counter=0, serdes_rst=1, video_rstn=0, ready=0, relock_count=0.
REQ-029 Deassertion of resetn mid-sequence SHALL restart from WAIT_LOCK; relock_count SHALL NOT survive reset.

Structure
REQ-030 The state encodings and default parameter values SHALL live in the shared package hdmi_pkg.
REQ-031 The synchronizer SHALL be a separate sub-module, sync_ff, parameterized by depth and also reusable for other clock-crossing signals.

Verification
REQ-032 Clean bring-up: parameters 8/4/4; raise pll_lock at cycle 10 -> ready=1 exactly 8+4+4+1 cycles after lock_s rises; serdes_rst falls 4 cycles before video_rstn rises.
REQ-033 Glitchy lock: pll_lock drops for 1 cycle mid-STABILIZE -> returns to WAIT_LOCK, counter restarts, relock_count stays 0.
REQ-034 Lock loss in RUN: drop pll_lock -> within SYNC_STAGES+1 cycles ready=0, serdes_rst=1, video_rstn=0, relock_count=1; repeat 300 times -> relock_count=255.
REQ-035 Soft reset: pulse soft_reset_req in RUN -> SERDES_RST for 4 cycles, VIDEO_RST for 4 cycles, then RUN; relock_count unchanged.
REQ-036 Simultaneous events: soft_reset_req and lock_s=0 on the same cycle -> WAIT_LOCK.
REQ-037 Reset mid-operation: assert resetn=0 during VIDEO_RST -> all outputs take their reset values asynchronously, before the next clk edge.
